aes_key_expander: RTL and testbench

Iterative AES-128 key schedule engine. Accepts one 128-bit cipher key over a valid/ready handshake and streams the 11 round keys (round 0 through round 10) over a second valid/ready handshake, one per accepted beat. It sits directly upstream of the AES round datapath and is the consumer of the shared S-box and Rcon tables in `aes_model_pack`.

---
 rtl/aes_model_pack.sv | 36 +++
 rtl/aes_sub_word.sv | 16 +
 rtl/aes_key_expander.sv | 101 ++++++++++
 tb/tb_aes_key_expander.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_model_pack.sv
// Shared AES constants and types: S-box, round constants and the AES-128 key layout.
package aes_model_pack;

    localparam int unsigned AES128_NUM_ROUNDS = 10;
    localparam int unsigned AES_WORD_BYTES    = 4;

    // Byte 0 of a word/key sits in the most significant position (FIPS-197 order).
    typedef logic [0:AES_WORD_BYTES-1][7:0] word_t;
    typedef word_t [0:3]                    aes128_key_t;

    localparam logic [7:0] SUB_BYTES_TABLE [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Entry r-1 is Rcon(r); only the top byte is non-zero.
    localparam word_t RCON_TABLE [0:AES128_NUM_ROUNDS-1] = '{
        32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
        32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000
    };

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word (shared with the round datapath).
module aes_sub_word
    import aes_model_pack::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    always_comb begin
        word_out = '0;
        for (int i = 0; i < 4; i++) begin
            word_out[8*i +: 8] = SUB_BYTES_TABLE[word_in[8*i +: 8]];
        end
    end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: accepts a cipher key, streams round keys 0..10 one per accepted beat.
module aes_key_expander
    import aes_model_pack::*;
#(
    parameter int unsigned ROUND_IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [127:0]           key_in,
    input  logic                   key_valid,
    output logic                   key_ready,
    output logic [127:0]           round_key,
    output logic [ROUND_IDX_W-1:0] round_idx,
    output logic                   round_last,
    output logic                   round_key_valid,
    input  logic                   round_key_ready
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] EXPAND = 1'b1;

    localparam int unsigned           RCON_IDX_W = $clog2(AES128_NUM_ROUNDS);
    localparam logic [ROUND_IDX_W-1:0] LAST_IDX  = ROUND_IDX_W'(AES128_NUM_ROUNDS);

    logic [0:0]             state_q;
    logic [0:0]             state_d;
    aes128_key_t            key_q;
    aes128_key_t            key_d;
    aes128_key_t            key_next;
    logic [ROUND_IDX_W-1:0] idx_d;
    logic                   last_d;
    logic [RCON_IDX_W-1:0]  rcon_idx;
    word_t                  rot_w;
    word_t                  sub_w;
    word_t                  temp_w;
    word_t                  n0, n1, n2, n3;

    // Next round key from the registered key; Rcon index clamped once the last round is shown.
    assign rot_w    = {key_q[3][1], key_q[3][2], key_q[3][3], key_q[3][0]};
    assign rcon_idx = round_last ? '0 : RCON_IDX_W'(round_idx);

    aes_sub_word u_sub_word (
        .word_in  (rot_w),
        .word_out (sub_w)
    );

    assign temp_w   = sub_w ^ RCON_TABLE[rcon_idx];
    assign n0       = key_q[0] ^ temp_w;
    assign n1       = key_q[1] ^ n0;
    assign n2       = key_q[2] ^ n1;
    assign n3       = key_q[3] ^ n2;
    assign key_next = {n0, n1, n2, n3};

    assign key_ready       = (state_q == IDLE);
    assign round_key_valid = (state_q == EXPAND);
    assign round_key       = key_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            round_idx  <= '0;
            round_last <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            round_idx  <= idx_d;
            round_last <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = round_idx;
        last_d  = round_last;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    key_d   = key_in;
                    idx_d   = '0;
                    last_d  = 1'b0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                if (round_key_ready) begin
                    if (round_last) begin
                        state_d = IDLE;
                    end else begin
                        key_d  = key_next;
                        idx_d  = round_idx + ROUND_IDX_W'(1);
                        last_d = ((round_idx + ROUND_IDX_W'(1)) == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 A.1 and all-zero key vectors.
module tb_aes_key_expander;

    localparam int unsigned RW = 4;

    logic          clk;
    logic          rst;
    logic [127:0]  key_in;
    logic          key_valid;
    logic          key_ready;
    logic [127:0]  round_key;
    logic [RW-1:0] round_idx;
    logic          round_last;
    logic          round_key_valid;
    logic          round_key_ready;

    int checks;
    int failures;
    int edges;

    logic [127:0] exp_a1 [0:10];
    logic [127:0] exp_z  [0:10];
    logic [10:0]  known_z;

    aes_key_expander #(.ROUND_IDX_W(RW)) dut (
        .clk             (clk),
        .rst             (rst),
        .key_in          (key_in),
        .key_valid       (key_valid),
        .key_ready       (key_ready),
        .round_key       (round_key),
        .round_idx       (round_idx),
        .round_last      (round_last),
        .round_key_valid (round_key_valid),
        .round_key_ready (round_key_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        checks++;
        failures++;
        $error("FAIL %s wait bound expired", tag);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a key and wait for it to be accepted; leaves key_valid low afterwards.
    task automatic send_key(input logic [127:0] k);
        int n;
        key_in    = k;
        key_valid = 1'b1;
        n = 0;
        while (!key_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) bound_fail("send_key");
        tick();
        key_valid = 1'b0;
        chk("accept_key", round_key, k);
        chk("accept_idx", 128'(round_idx), 128'(0));
        chk("accept_valid", 128'(round_key_valid), 128'(1));
    endtask

    // Consume the 11 beats of one expansion, optionally with random backpressure.
    task automatic collect(input int sel, input bit rnd, output int n_edges);
        logic [127:0] e;
        bit           k;
        int           n;
        n_edges = 0;
        for (int b = 0; b <= 10; b++) begin
            e = (sel == 0) ? exp_a1[b] : exp_z[b];
            k = (sel == 0) ? 1'b1 : known_z[b];
            if (k) chk($sformatf("key_r%0d", b), round_key, e);
            chk($sformatf("idx_r%0d", b), 128'(round_idx), 128'(b));
            chk($sformatf("last_r%0d", b), 128'(round_last), 128'(b == 10));
            chk($sformatf("valid_r%0d", b), 128'(round_key_valid), 128'(1));
            chk($sformatf("kready_r%0d", b), 128'(key_ready), 128'(0));
            round_key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n = 0;
            while (!round_key_ready) begin
                tick();
                n_edges++;
                n++;
                if (k) chk($sformatf("hold_key_r%0d", b), round_key, e);
                chk($sformatf("hold_idx_r%0d", b), 128'(round_idx), 128'(b));
                chk($sformatf("hold_last_r%0d", b), 128'(round_last), 128'(b == 10));
                chk($sformatf("hold_valid_r%0d", b), 128'(round_key_valid), 128'(1));
                round_key_ready = 1'($urandom_range(0, 1));
                if (n >= 64) begin
                    bound_fail("stall");
                    round_key_ready = 1'b1;
                end
            end
            tick();
            n_edges++;
        end
        round_key_ready = 1'b0;
        chk("end_valid", 128'(round_key_valid), 128'(0));
        chk("end_kready", 128'(key_ready), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst      = 1'b1;
        key_in   = '0;
        key_valid       = 1'b0;
        round_key_ready = 1'b0;

        exp_a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i <= 10; i++) exp_z[i] = '0;
        exp_z[1]  = 128'h62636363626363636263636362636363;
        exp_z[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        known_z   = 11'b100_0000_0011;

        // Reset state
        #1;
        chk("rst_key", round_key, 128'h0);
        chk("rst_idx", 128'(round_idx), 128'(0));
        chk("rst_last", 128'(round_last), 128'(0));
        chk("rst_valid", 128'(round_key_valid), 128'(0));
        chk("rst_kready", 128'(key_ready), 128'(1));
        tick();
        #2 rst = 1'b0;
        tick();

        // A.1 key, no backpressure, with throughput check
        send_key(exp_a1[0]);
        collect(0, 1'b0, edges);
        chk("a1_edges", 128'(edges), 128'(11));

        // A.1 key with random backpressure
        send_key(exp_a1[0]);
        collect(0, 1'b1, edges);

        // Second key held during expansion
        send_key(exp_a1[0]);
        key_in    = 128'h0;
        key_valid = 1'b1;
        collect(0, 1'b0, edges);
        tick();
        key_valid = 1'b0;
        chk("second_key_r0", round_key, 128'h0);
        chk("second_idx_r0", 128'(round_idx), 128'(0));
        chk("second_valid", 128'(round_key_valid), 128'(1));
        collect(1, 1'b0, edges);

        // Async reset mid-expansion at round 5 with ready low
        send_key(exp_a1[0]);
        round_key_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        round_key_ready = 1'b0;
        tick();
        chk("pre_rst_idx", 128'(round_idx), 128'(5));
        chk("pre_rst_key", round_key, exp_a1[5]);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_key", round_key, 128'h0);
        chk("mid_rst_idx", 128'(round_idx), 128'(0));
        chk("mid_rst_last", 128'(round_last), 128'(0));
        chk("mid_rst_valid", 128'(round_key_valid), 128'(0));
        chk("mid_rst_kready", 128'(key_ready), 128'(1));
        tick();
        #2 rst = 1'b0;
        tick();
        send_key(exp_a1[0]);
        collect(0, 1'b0, edges);
        chk("post_rst_edges", 128'(edges), 128'(11));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
